spi_frame_shifter: RTL and testbench
====================================

# spi_frame_shifter

Parametrised full-duplex serial/parallel frame shifter for the SPI peripheral. It is the next-generation replacement for the fixed 8-bit shift register. It adds configurable width and bit order, a frame bit counter, a one-deep transmit holding buffer with valid/ready handshake, receive-word capture with a done strobe, chip-select abort, and back-to-back frame support. It sits between the SPI pin synchroniser/edge detector and the multiplier register interface, all in the `clk` domain.

## Interface
- `WIDTH`, 8, frame length in bits (≥2)
- `MSB_FIRST`, 1, 1: MSB shifted first on both lines; 0: LSB first
- `clk`  in  1  system clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `cs_n`  in  1  synchronised chip select, active low
- `sclk_rise`  in  1  one-`clk` pulse per serial-clock sample edge
- `sclk_fall`  in  1  one-`clk` pulse per serial-clock drive edge
- `mosi`  in  1  synchronised serial data in
- `miso`  out  1  registered serial data out
- `tx_data`  in  WIDTH  word to transmit next
- `tx_valid`  in  1  `tx_data` valid
- `tx_ready`  out  1  holding buffer empty; transfer occurs when `tx_valid && tx_ready`
- `rx_data`  out  WIDTH  last completely received frame
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates
- `underrun`  out  1  one-cycle pulse when a frame starts with an empty holding buffer
- `busy`  out  1  frame in progress (state ACTIVE)
- `bit_cnt`  out  $clog2(WIDTH+1)  bits sampled in current frame

## Operation
- Internal state: `tx_buf`/`tx_full`, `tx_sr` and `rx_sr` (WIDTH each), `bit_cnt`, `reload_pending`, and a 2-state FSM IDLE/ACTIVE.
- Reset: IDLE; `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `underrun`=0, `busy`=0, `bit_cnt`=0, all shift registers and `tx_buf` = 0.
- Handshake: `tx_ready` = !`tx_full`. On accept, `tx_buf`←`tx_data` and `tx_full`←1. `tx_buf` is consumed only at a load.
- IDLE→ACTIVE when `cs_n`=0. In the same edge, load `tx_sr`←`tx_buf` and clear `tx_full` if full. Otherwise load `tx_sr`←0 and pulse `underrun`. A `tx_valid` accepted in that same cycle goes into `tx_buf` for the next frame and is not part of this frame. Clear `bit_cnt`.
- `miso` = out-bit of `tx_sr` (bit WIDTH-1 if `MSB_FIRST`, else bit 0), registered. It is 0 in IDLE.
- ACTIVE, `sclk_rise`:
  - `rx_sr` shifts in `mosi`: shift left with `mosi` at LSB if `MSB_FIRST`; else shift right with `mosi` at MSB.
  - `bit_cnt`++.
  - If `bit_cnt` becomes WIDTH: `rx_data`←assembled word, `rx_valid` pulses, `bit_cnt`←0, `reload_pending`←1.
- ACTIVE, `sclk_fall`:
  - If `reload_pending`: reload `tx_sr` from `tx_buf` under the same full/underrun rules as a frame start, and clear `reload_pending`.
  - Otherwise `tx_sr` shifts toward the out-bit and fills with 0.
- `sclk_rise` and `sclk_fall` asserted in the same cycle: the rise is processed and the fall is ignored.
- `cs_n`=1 while ACTIVE: abort and go to IDLE. Partial `rx_sr` is discarded with no `rx_valid`. `bit_cnt`←0, `reload_pending`←0, `miso`←0. `tx_buf`/`tx_full` are unchanged; a word already loaded into `tx_sr` is lost.
- Edge pulses while IDLE are ignored.

## Timing
- `miso` is valid one `clk` after the `cs_n` low is seen and one `clk` after each `sclk_fall`.
- `rx_valid`, `rx_data` and `underrun` are registered: they are asserted on the clock edge that processes the triggering event, visible the following cycle, and last exactly one cycle.
- `tx_ready` falls the cycle after an accept and rises the cycle after a load consumes `tx_buf`.
- Back-to-back frames: the next frame's first bit is on `miso` one `clk` after the `sclk_fall` that follows the final `sclk_rise`. `cs_n` stays low and no gap is needed.
- Reset is asynchronous: asserting `rst_n`=0 mid-frame forces all outputs to their reset values immediately, with no `rx_valid`.

## Test plan
- **Full frame, MSB first:** WIDTH=8. Load `tx_data`=0xA5, drop `cs_n`, then drive 8 fall/rise pairs with `mosi` carrying 0x3C MSB first. Required: `miso` sequence 1,0,1,0,0,1,0,1; `rx_data`=0x3C; single `rx_valid` pulse after the 8th rise; `tx_ready` back to 1.
- **LSB first:** `MSB_FIRST`=0. Send 0x01 and receive 0x80. Required: first `miso` bit is 1, `rx_data`=0x80.
- **Back-to-back with underrun:** queue 0x11, run two frames without raising `cs_n`. Required: second frame transmits 0x00, `underrun` pulses once at the reload, and two `rx_valid` pulses occur.
- **Abort:** raise `cs_n` after 5 rises. Required: no `rx_valid`, `bit_cnt`=0, `miso`=0. The next frame receives a full fresh word correctly.
- **Simultaneous events:** assert `tx_valid` on the same cycle `cs_n` falls with an empty buffer. Required: `underrun` pulses, the frame sends 0x00, and the word goes out in the next frame. Also assert `sclk_rise`+`sclk_fall` together; required: only the sample occurs and `miso` is unchanged.
- **Async reset mid-frame:** pull `rst_n` low between clock edges. Required: all outputs at reset values before the next `clk` edge.

Source files
------------

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: full-duplex serial/parallel frame shifter for the SPI
// peripheral. Configurable width and bit order, one-deep transmit holding
// buffer with valid/ready handshake, receive capture with a done strobe,
// chip-select abort and back-to-back frames without a chip-select gap.
module spi_frame_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cs_n,
  input  logic                       sclk_rise,
  input  logic                       sclk_fall,
  input  logic                       mosi,
  output logic                       miso,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [WIDTH-1:0]           rx_data,
  output logic                       rx_valid,
  output logic                       underrun,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LP_LAST = CW'(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_full;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] r_rx_data;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_reload_pending;
  logic             r_miso;
  logic             r_rx_valid;
  logic             r_underrun;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;
  logic [WIDTH-1:0] w_tx_shift;
  logic [WIDTH-1:0] w_rx_shift;
  logic [CW-1:0]    w_cnt_inc;

  // Bit presented on miso for a given transmit shift-register value.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Handshake, load and shift helpers shared by the FSM and the holding buffer.
  always_comb begin
    w_accept    = tx_valid && !r_tx_full;
    // A load happens at frame start and at the first drive edge after a
    // completed frame; a rise in the same cycle suppresses the fall.
    w_load      = !cs_n && ((r_state == S_IDLE) ||
                            (sclk_fall && !sclk_rise && r_reload_pending));
    w_load_word = r_tx_full ? r_tx_buf : '0;
    w_cnt_inc   = r_bit_cnt + CW'(1);
    if (MSB_FIRST) begin
      w_tx_shift = {r_tx_sr[WIDTH-2:0], 1'b0};
      w_rx_shift = {r_rx_sr[WIDTH-2:0], mosi};
    end else begin
      w_tx_shift = {1'b0, r_tx_sr[WIDTH-1:1]};
      w_rx_shift = {mosi, r_rx_sr[WIDTH-1:1]};
    end
  end

  // One-deep transmit holding buffer. Accept and consume never coincide:
  // accept needs an empty buffer and a consuming load needs a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else if (w_accept) begin
      r_tx_buf  <= tx_data;
      r_tx_full <= 1'b1;
    end else if (w_load) begin
      r_tx_full <= 1'b0;
    end
  end

  // Frame FSM with shift registers, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_tx_sr          <= '0;
      r_rx_sr          <= '0;
      r_rx_data        <= '0;
      r_bit_cnt        <= '0;
      r_reload_pending <= 1'b0;
      r_miso           <= 1'b0;
      r_rx_valid       <= 1'b0;
      r_underrun       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (!cs_n) begin
            r_state          <= S_ACTIVE;
            r_tx_sr          <= w_load_word;
            r_miso           <= out_bit(w_load_word);
            r_underrun       <= !r_tx_full;
            r_rx_sr          <= '0;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (cs_n) begin
            r_state          <= S_IDLE;
            r_tx_sr          <= '0;
            r_rx_sr          <= '0;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b0;
            r_miso           <= 1'b0;
          end else if (sclk_rise) begin
            r_rx_sr <= w_rx_shift;
            if (w_cnt_inc == LP_LAST) begin
              r_rx_data        <= w_rx_shift;
              r_rx_valid       <= 1'b1;
              r_bit_cnt        <= '0;
              r_reload_pending <= 1'b1;
            end else begin
              r_bit_cnt <= w_cnt_inc;
            end
          end else if (sclk_fall) begin
            if (r_reload_pending) begin
              r_tx_sr          <= w_load_word;
              r_miso           <= out_bit(w_load_word);
              r_underrun       <= !r_tx_full;
              r_reload_pending <= 1'b0;
            end else begin
              r_tx_sr <= w_tx_shift;
              r_miso  <= out_bit(w_tx_shift);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso     = r_miso;
  assign tx_ready = !r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign underrun = r_underrun;
  assign busy     = (r_state == S_ACTIVE);
  assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Bench for spi_frame_shifter: one MSB-first and one LSB-first instance
// share all inputs; a transaction-level model predicts every output.
module tb_spi_frame_shifter;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          sclk_rise = 1'b0;
  logic          sclk_fall = 1'b0;
  logic          mosi = 1'b0;
  logic          tx_valid = 1'b0;
  logic [W-1:0]  tx_data = '0;

  logic          miso_m, tx_ready_m, rx_valid_m, underrun_m, busy_m;
  logic [W-1:0]  rx_data_m;
  logic [CW-1:0] bit_cnt_m;
  logic          miso_l, tx_ready_l, rx_valid_l, underrun_l, busy_l;
  logic [W-1:0]  rx_data_l;
  logic [CW-1:0] bit_cnt_l;

  spi_frame_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall), .mosi(mosi), .miso(miso_m), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready_m), .rx_data(rx_data_m),
    .rx_valid(rx_valid_m), .underrun(underrun_m), .busy(busy_m),
    .bit_cnt(bit_cnt_m)
  );

  spi_frame_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall), .mosi(mosi), .miso(miso_l), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready_l), .rx_data(rx_data_l),
    .rx_valid(rx_valid_l), .underrun(underrun_l), .busy(busy_l),
    .bit_cnt(bit_cnt_l)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words in a queue, the current frame as a word plus a
  // bit index, received bits as a list assembled arithmetically.
  bit           m_active;
  logic [W-1:0] m_hold_q[$];
  logic [W-1:0] m_frame;
  int           m_idx;
  bit           m_rxbits[$];
  bit           m_pend;
  logic [W-1:0] m_rxd_m, m_rxd_l;
  bit           m_rxv, m_und;

  task automatic model_reset();
    m_active = 1'b0;
    m_hold_q.delete();
    m_frame  = '0;
    m_idx    = 0;
    m_rxbits.delete();
    m_pend   = 1'b0;
    m_rxd_m  = '0;
    m_rxd_l  = '0;
    m_rxv    = 1'b0;
    m_und    = 1'b0;
  endtask

  task automatic model_load();
    if (m_hold_q.size() > 0) m_frame = m_hold_q.pop_front();
    else begin
      m_frame = '0;
      m_und   = 1'b1;
    end
    m_idx = 0;
  endtask

  function automatic logic exp_miso(input bit msb);
    if (!m_active || m_idx >= W) return 1'b0;
    return msb ? m_frame[W-1-m_idx] : m_frame[m_idx];
  endfunction

  task automatic check_outputs();
    chk("miso_m",     32'(miso_m),     32'(exp_miso(1'b1)));
    chk("miso_l",     32'(miso_l),     32'(exp_miso(1'b0)));
    chk("tx_ready_m", 32'(tx_ready_m), 32'(m_hold_q.size() == 0));
    chk("tx_ready_l", 32'(tx_ready_l), 32'(m_hold_q.size() == 0));
    chk("rx_data_m",  32'(rx_data_m),  32'(m_rxd_m));
    chk("rx_data_l",  32'(rx_data_l),  32'(m_rxd_l));
    chk("rx_valid_m", 32'(rx_valid_m), 32'(m_rxv));
    chk("rx_valid_l", 32'(rx_valid_l), 32'(m_rxv));
    chk("underrun_m", 32'(underrun_m), 32'(m_und));
    chk("underrun_l", 32'(underrun_l), 32'(m_und));
    chk("busy_m",     32'(busy_m),     32'(m_active));
    chk("busy_l",     32'(busy_l),     32'(m_active));
    chk("bit_cnt_m",  32'(bit_cnt_m),  32'(m_rxbits.size()));
    chk("bit_cnt_l",  32'(bit_cnt_l),  32'(m_rxbits.size()));
  endtask

  // Drive one clock of inputs, advance the model, then check all outputs.
  task automatic cyc(input bit cs, input bit rise, input bit fall, input bit md,
                     input bit valid, input logic [W-1:0] data);
    bit acc;
    int unsigned vm, vl;
    cs_n      = cs;
    sclk_rise = rise;
    sclk_fall = fall;
    mosi      = md;
    tx_valid  = valid;
    tx_data   = data;
    acc       = valid && (m_hold_q.size() == 0);
    @(posedge clk);
    #1;
    m_rxv = 1'b0;
    m_und = 1'b0;
    if (!m_active) begin
      if (!cs) begin
        m_active = 1'b1;
        model_load();
        m_rxbits.delete();
        m_pend = 1'b0;
      end
    end else if (cs) begin
      m_active = 1'b0;
      m_rxbits.delete();
      m_pend = 1'b0;
    end else if (rise) begin
      m_rxbits.push_back(md);
      if (m_rxbits.size() == W) begin
        vm = 0;
        vl = 0;
        for (int i = 0; i < W; i++) begin
          vm = vm | (int'(m_rxbits[i]) << (W - 1 - i));
          vl = vl | (int'(m_rxbits[i]) << i);
        end
        m_rxd_m = W'(vm);
        m_rxd_l = W'(vl);
        m_rxv   = 1'b1;
        m_rxbits.delete();
        m_pend  = 1'b1;
      end
    end else if (fall) begin
      if (m_pend) begin
        model_load();
        m_pend = 1'b0;
      end else begin
        m_idx++;
      end
    end
    if (acc) m_hold_q.push_back(data);
    check_outputs();
  endtask

  task automatic push(input bit cs, input logic [W-1:0] w);
    cyc(cs, 1'b0, 1'b0, 1'b0, 1'b1, w);
  endtask

  // Sample/drive pairs with mosi carrying word MSB first on the wire.
  task automatic send_bits(input logic [W-1:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, word[W-1-i], 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    bit cur_cs;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Full frame: transmit 0xA5, receive 0x3C on the wire.
    push(1'b1, 8'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'h3C, W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // 0x01 transmit; wire carries 0x01 MSB first (0x80 to the LSB-first unit).
    push(1'b1, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'h01, W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Back-to-back frames with the second one underrunning.
    push(1'b1, 8'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'h5A, W);
    send_bits(8'hC3, W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Abort after five samples, then a fresh full frame.
    push(1'b1, 8'h77);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'hFF, 5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b1, 8'h3E);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'h96, W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Accept on the frame-start cycle with an empty buffer, then a
    // simultaneous rise+fall in the middle of the following frame.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE7);
    send_bits(8'h24, W);
    send_bits(8'h42, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    send_bits(8'h0F, 4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Edge pulses while idle are ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic.
    cur_cs = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) cur_cs = ~cur_cs;
      cyc(cur_cs, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
          1'($urandom), $urandom_range(0, 9) < 3, W'($urandom));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset between clock edges in the middle of a frame.
    push(1'b1, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'hAA, 3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    push(1'b0, 8'h99);
    #3;
    cs_n  = 1'b1;
    tx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    push(1'b1, 8'hB4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    send_bits(8'h6D, W);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
